// File: rtl/wb_data_master_if.sv
// Wishbone classic bus bundle between the J1 data-port initiator and the
// shared RAM/ROM responder.
//   cyc_o/stb_o/we_o : cycle, strobe, write enable (initiator -> responder)
//   adr_o/dat_o      : address and write data      (initiator -> responder)
//   dat_i/ack_i      : read data and acknowledge   (responder -> initiator)
// Signal names carry the initiator's point of view.
interface wb_data_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/wb_data_master.sv
// wb_data_master: turns a J1 single-cycle data load/store request into a
// classic Wishbone read/write cycle, returns read data with a one-cycle
// done pulse, and always inserts one idle (END) cycle after a transfer so a
// registered ack from the responder is never counted twice.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   req_i      CPU request, sampled only in IDLE
//   req_we_i   1 = write, 0 = read
//   req_adr_i  address, passed through unchanged
//   req_dat_i  write data
//   busy_o     high whenever the machine is not IDLE
//   done_o     one-cycle completion pulse
//   rdata_o    read data, held until the next read completes
//   err_o      one-cycle timeout pulse (0 unless WB_TIMEOUT_EN)
//   wb         Wishbone master bundle (cyc/stb/we/adr/dat_o, dat_i/ack)
//
// Build option: define WB_TIMEOUT_EN to abort a BUS phase after TIMEOUT
// cycles without ack (done_o and err_o pulse together, reads return 0).
// All outputs are registered.
module wb_data_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [31:0]           req_adr_i,
  input  logic [31:0]           req_dat_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  wb_data_master_if.master      wb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q,   cyc_d;
  logic        stb_q,   stb_d;
  logic        we_q,    we_d;
  logic [31:0] adr_q,   adr_d;
  logic [31:0] dat_q,   dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q,  done_d;
  logic        busy_q,  busy_d;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and next-output logic. Outputs hold by default; only the
  // transitions below change them.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_BUS: begin
        if (wb.ack_i) begin
          state_d = S_END;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = wb.dat_i;
        end
`ifdef WB_TIMEOUT_EN
        // cnt_q counts BUS cycles already spent without ack; the current
        // cycle is the TIMEOUT-th, so abort now. Ack in this cycle wins
        // because it is tested first.
        else if (cnt_q == CNT_LAST) begin
          state_d = S_END;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      // Guard cycle: a responder that registered ack from the last strobe
      // may still assert ack here; it is deliberately ignored.
      S_END: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = stb_q;
  assign wb.we_o  = we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign rdata_o  = rdata_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;

`ifdef WB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_data_master.sv
// Directed bench for wb_data_master. Each step advances one clock, samples
// outputs 1 time unit after the rising edge, then drives the inputs for the
// current cycle. Cycle numbering follows the transfer: cycle 0 is the cycle
// in which req_i is presented in IDLE.
module tb_wb_data_master;
  logic        clk;
  logic        rst;
  logic        req_i;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int total;
  int bad;

  wb_data_master_if wb ();

  wb_data_master #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_we_i  (req_we_i),
    .req_adr_i (req_adr_i),
    .req_dat_i (req_dat_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .wb        (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst       = 1'b0;
    req_i     = 1'b0;
    req_we_i  = 1'b0;
    req_adr_i = '0;
    req_dat_i = '0;
    wb.ack_i  = 1'b0;
    wb.dat_i  = '0;

    // ---- reset state
    #3;
    chk("rst_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o},   32'd0);
    chk("rst_done",  {31'd0, done_o},   32'd0);
    chk("rst_rdata", rdata_o,           32'h0);
    chk("rst_err",   {31'd0, err_o},    32'd0);
    tick();
    rst = 1'b1;
    tick();

    // ---- ack in IDLE is ignored
    wb.ack_i = 1'b1;
    tick();
    chk("idle_ack_busy", {31'd0, busy_o},   32'd0);
    chk("idle_ack_cyc",  {31'd0, wb.cyc_o}, 32'd0);
    chk("idle_ack_done", {31'd0, done_o},   32'd0);
    wb.ack_i = 1'b0;

    // ---- write 0x1004 <= DEADBEEF, ack at k=2 (cycle 0 here)
    req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h1004; req_dat_i = 32'hDEADBEEF;
    tick(); // cycle 1
    chk("wr_c1_cyc",  {31'd0, wb.cyc_o}, 32'd1);
    chk("wr_c1_stb",  {31'd0, wb.stb_o}, 32'd1);
    chk("wr_c1_we",   {31'd0, wb.we_o},  32'd1);
    chk("wr_c1_adr",  wb.adr_o,          32'h1004);
    chk("wr_c1_dat",  wb.dat_o,          32'hDEADBEEF);
    chk("wr_c1_busy", {31'd0, busy_o},   32'd1);
    req_i = 1'b0; req_we_i = 1'b0; req_adr_i = 32'hFFFF; req_dat_i = 32'h0;
    tick(); // cycle 2
    chk("wr_c2_cyc",  {31'd0, wb.cyc_o}, 32'd1);
    chk("wr_c2_adr",  wb.adr_o,          32'h1004);
    chk("wr_c2_dat",  wb.dat_o,          32'hDEADBEEF);
    chk("wr_c2_done", {31'd0, done_o},   32'd0);
    wb.ack_i = 1'b1;
    tick(); // cycle 3
    chk("wr_c3_done",  {31'd0, done_o},   32'd1);
    chk("wr_c3_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("wr_c3_busy",  {31'd0, busy_o},   32'd1);
    chk("wr_c3_rdata", rdata_o,           32'h0);
    chk("wr_c3_err",   {31'd0, err_o},    32'd0);
    // stale registered ack in END
    tick(); // cycle 4
    chk("wr_c4_done", {31'd0, done_o},   32'd0);
    chk("wr_c4_busy", {31'd0, busy_o},   32'd0);
    wb.ack_i = 1'b0;

    // ---- read 0x1004, responder returns DEADBEEF at k=2 (cycle 0 here)
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h1004;
    tick(); // cycle 1
    chk("rd_c1_cyc", {31'd0, wb.cyc_o}, 32'd1);
    chk("rd_c1_we",  {31'd0, wb.we_o},  32'd0);
    chk("rd_c1_adr", wb.adr_o,          32'h1004);
    req_i = 1'b0;
    tick(); // cycle 2
    chk("rd_c2_we", {31'd0, wb.we_o}, 32'd0);
    wb.ack_i = 1'b1; wb.dat_i = 32'hDEADBEEF;
    tick(); // cycle 3
    chk("rd_c3_done",  {31'd0, done_o}, 32'd1);
    chk("rd_c3_rdata", rdata_o,         32'hDEADBEEF);
    chk("rd_c3_we",    {31'd0, wb.we_o}, 32'd0);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick(); // cycle 4
    chk("rd_c4_done",  {31'd0, done_o}, 32'd0);
    chk("rd_c4_rdata", rdata_o,         32'hDEADBEEF);

    // ---- ack held 2 cycles, req held high throughout (cycle 0 here)
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h2000;
    tick(); // cycle 1
    chk("hold_c1_cyc",  {31'd0, wb.cyc_o}, 32'd1);
    chk("hold_c1_done", {31'd0, done_o},   32'd0);
    tick(); // cycle 2
    chk("hold_c2_cyc", {31'd0, wb.cyc_o}, 32'd1);
    wb.ack_i = 1'b1; wb.dat_i = 32'h11111111;
    tick(); // cycle 3
    chk("hold_c3_done",  {31'd0, done_o},   32'd1);
    chk("hold_c3_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("hold_c3_rdata", rdata_o,           32'h11111111);
    wb.dat_i = 32'h22222222; // second ack cycle, lands in END
    tick(); // cycle 4
    chk("hold_c4_done",  {31'd0, done_o},   32'd0);
    chk("hold_c4_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("hold_c4_busy",  {31'd0, busy_o},   32'd0);
    chk("hold_c4_rdata", rdata_o,           32'h11111111);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick(); // cycle 5: second transfer
    chk("hold_c5_cyc",  {31'd0, wb.cyc_o}, 32'd1);
    chk("hold_c5_done", {31'd0, done_o},   32'd0);
    req_i = 1'b0;
    tick(); // cycle 6
    chk("hold_c6_cyc", {31'd0, wb.cyc_o}, 32'd1);
    wb.ack_i = 1'b1; wb.dat_i = 32'h33333333;
    tick(); // cycle 7
    chk("hold_c7_done",  {31'd0, done_o}, 32'd1);
    chk("hold_c7_rdata", rdata_o,         32'h33333333);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick(); // cycle 8
    chk("hold_c8_busy", {31'd0, busy_o}, 32'd0);

    // ---- write with wait states, k=6 (cycle 0 here)
    req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h3000; req_dat_i = 32'h55AA55AA;
    for (int c = 1; c <= 6; c++) begin
      tick();
      req_i = 1'b0; req_adr_i = 32'h0; req_dat_i = 32'h0;
      chk($sformatf("ws_c%0d_cyc", c),  {31'd0, wb.cyc_o}, 32'd1);
      chk($sformatf("ws_c%0d_adr", c),  wb.adr_o,          32'h3000);
      chk($sformatf("ws_c%0d_done", c), {31'd0, done_o},   32'd0);
      if (c == 6) begin
        wb.ack_i = 1'b1;
        wb.dat_i = 32'hBAD0BAD0;
      end
    end
    tick(); // cycle 7
    chk("ws_c7_done",  {31'd0, done_o},   32'd1);
    chk("ws_c7_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("ws_c7_rdata", rdata_o,           32'h33333333);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick(); // cycle 8
    chk("ws_c8_busy", {31'd0, busy_o}, 32'd0);

    // ---- asynchronous reset in the middle of BUS
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h4000;
    tick(); // cycle 1
    chk("mrst_pre_cyc", {31'd0, wb.cyc_o}, 32'd1);
    req_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mrst_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("mrst_stb",   {31'd0, wb.stb_o}, 32'd0);
    chk("mrst_busy",  {31'd0, busy_o},   32'd0);
    chk("mrst_done",  {31'd0, done_o},   32'd0);
    chk("mrst_rdata", rdata_o,           32'h0);
    #2 rst = 1'b1;
    tick();
    chk("mrst_idle_busy", {31'd0, busy_o},   32'd0);
    chk("mrst_idle_cyc",  {31'd0, wb.cyc_o}, 32'd0);
    // new read accepted after reset
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h5000;
    tick(); // cycle 1
    chk("post_c1_cyc", {31'd0, wb.cyc_o}, 32'd1);
    chk("post_c1_adr", wb.adr_o,          32'h5000);
    req_i = 1'b0;
    wb.ack_i = 1'b1; wb.dat_i = 32'hCAFEF00D;
    tick(); // cycle 2 (k=1)
    chk("post_c2_done",  {31'd0, done_o}, 32'd1);
    chk("post_c2_rdata", rdata_o,         32'hCAFEF00D);
    chk("post_c2_err",   {31'd0, err_o},  32'd0);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick(); // cycle 3
    chk("post_c3_busy", {31'd0, busy_o}, 32'd0);

`ifdef WB_TIMEOUT_EN
    // ---- timeout: no ack for 16 BUS cycles (cycle 0 here)
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h6000;
    for (int c = 1; c <= 16; c++) begin
      tick();
      req_i = 1'b0;
      chk($sformatf("to_c%0d_cyc", c), {31'd0, wb.cyc_o}, 32'd1);
      chk($sformatf("to_c%0d_err", c), {31'd0, err_o},    32'd0);
    end
    tick(); // cycle 17
    chk("to_c17_cyc",   {31'd0, wb.cyc_o}, 32'd0);
    chk("to_c17_done",  {31'd0, done_o},   32'd1);
    chk("to_c17_err",   {31'd0, err_o},    32'd1);
    chk("to_c17_rdata", rdata_o,           32'h0);
    tick(); // cycle 18
    chk("to_c18_err",  {31'd0, err_o},  32'd0);
    chk("to_c18_busy", {31'd0, busy_o}, 32'd0);

    // ---- ack arrives on the final count cycle: ack wins
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h7000;
    for (int c = 1; c <= 16; c++) begin
      tick();
      req_i = 1'b0;
      chk($sformatf("tw_c%0d_cyc", c), {31'd0, wb.cyc_o}, 32'd1);
      if (c == 16) begin
        wb.ack_i = 1'b1;
        wb.dat_i = 32'h0BADF00D;
      end
    end
    tick(); // cycle 17
    chk("tw_c17_done",  {31'd0, done_o}, 32'd1);
    chk("tw_c17_err",   {31'd0, err_o},  32'd0);
    chk("tw_c17_rdata", rdata_o,         32'h0BADF00D);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick();
    chk("tw_c18_busy", {31'd0, busy_o}, 32'd0);
`else
    // ---- no timeout: BUS waits well past 16 cycles
    req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h6000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      req_i = 1'b0;
      chk($sformatf("nto_c%0d_cyc", c), {31'd0, wb.cyc_o}, 32'd1);
      chk($sformatf("nto_c%0d_err", c), {31'd0, err_o},    32'd0);
    end
    wb.ack_i = 1'b1; wb.dat_i = 32'h12345678;
    tick(); // cycle 21
    chk("nto_c21_done",  {31'd0, done_o}, 32'd1);
    chk("nto_c21_err",   {31'd0, err_o},  32'd0);
    chk("nto_c21_rdata", rdata_o,         32'h12345678);
    wb.ack_i = 1'b0; wb.dat_i = 32'h0;
    tick();
    chk("nto_c22_busy", {31'd0, busy_o}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
